// File: rtl/uart_tx_if.sv
// uart_tx_if -- request/serial-line bundle for uart_tx.
//
// Signals:
//   Prescale   [4:0]            clock cycles per serial bit (0-3 act as 4)
//   PAR_EN                      1 = parity bit inserted after the data bits
//   PAR_TYP                     0 = even parity, 1 = odd parity
//   P_DATA     [DATA_WIDTH-1:0] parallel word to transmit
//   Data_Valid                  transmit request, P_DATA valid this cycle
//   TX_OUT                      serial line, idle high
//   Busy                        frame in progress, requests ignored
//
// Modports:
//   master  -- request source (drives the request, observes line and Busy)
//   slave   -- the transmitter
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [4:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output Prescale,
    output PAR_EN,
    output PAR_TYP,
    output P_DATA,
    output Data_Valid,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  Prescale,
    input  PAR_EN,
    input  PAR_TYP,
    input  P_DATA,
    input  Data_Valid,
    output TX_OUT,
    output Busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- single-frame UART transmitter.
//
// A request (Data_Valid while not busy) captures the word, parity settings
// and prescale; the next cycle starts the frame: start bit (0), DATA_WIDTH
// data bits LSB first, optional parity bit, stop bit (1). Every bit lasts P
// clock cycles, P being the captured prescale with 0-3 promoted to 4.
//
// Ports:
//   CLK  -- oversampling clock, rising edge
//   RST  -- synchronous active-low reset, aborts any frame in progress
//   bus  -- uart_tx_if slave modport (request inputs, TX_OUT, Busy)
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity bit for a captured word: plain XOR for even, inverted for odd.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic odd);
    return (^d) ^ odd;
  endfunction

  // Prescale values below 4 are too short to be useful and run as 4.
  function automatic logic [4:0] eff_prescale(input logic [4:0] p);
    logic [4:0] r;
    if (p < 5'd4) begin
      r = 5'd4;
    end else begin
      r = p;
    end
    return r;
  endfunction

  state_t                state_r;
  state_t                next_state_s;
  logic [4:0]            timer_r;
  logic [4:0]            next_timer_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [CNT_W-1:0]      next_bit_cnt_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [4:0]            prescale_r;
  logic                  tx_out_r;
  logic                  busy_r;
  logic                  accept_s;
  logic                  last_tick_s;
  logic                  next_tx_s;
  logic                  next_busy_s;

  // Bit boundary: the timer has reached P-1 in the current bit.
  assign last_tick_s = (timer_r == (prescale_r - 5'd1));

  // Next-state, bit timer and data bit counter.
  always_comb begin
    next_state_s   = state_r;
    next_timer_s   = timer_r;
    next_bit_cnt_s = bit_cnt_r;
    accept_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Data_Valid) begin
          accept_s       = 1'b1;
          next_state_s   = START;
          next_timer_s   = 5'd0;
          next_bit_cnt_s = '0;
        end else begin
          next_state_s   = IDLE;
        end
      end
      START: begin
        if (last_tick_s) begin
          next_state_s = DATA;
          next_timer_s = 5'd0;
        end else begin
          next_timer_s = timer_r + 5'd1;
        end
      end
      DATA: begin
        if (last_tick_s) begin
          next_timer_s = 5'd0;
          if (bit_cnt_r == LAST_BIT) begin
            next_bit_cnt_s = '0;
            if (par_en_r) begin
              next_state_s = PARITY;
            end else begin
              next_state_s = STOP;
            end
          end else begin
            next_bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end else begin
          next_timer_s = timer_r + 5'd1;
        end
      end
      PARITY: begin
        if (last_tick_s) begin
          next_state_s = STOP;
          next_timer_s = 5'd0;
        end else begin
          next_timer_s = timer_r + 5'd1;
        end
      end
      STOP: begin
        if (last_tick_s) begin
          next_state_s = IDLE;
          next_timer_s = 5'd0;
        end else begin
          next_timer_s = timer_r + 5'd1;
        end
      end
      default: begin
        next_state_s   = IDLE;
        next_timer_s   = 5'd0;
        next_bit_cnt_s = '0;
      end
    endcase
  end

  // Line level and Busy for the next cycle, derived from the next state so
  // both outputs can be registered without a cycle of lag.
  always_comb begin
    next_tx_s   = 1'b1;
    next_busy_s = (next_state_s != IDLE);
    case (next_state_s)
      IDLE:    next_tx_s = 1'b1;
      START:   next_tx_s = 1'b0;
      DATA:    next_tx_s = data_r[next_bit_cnt_s];
      PARITY:  next_tx_s = parity_bit(data_r, par_typ_r);
      STOP:    next_tx_s = 1'b1;
      default: next_tx_s = 1'b1;
    endcase
  end

  // State, counters, captured request and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= IDLE;
      timer_r    <= 5'd0;
      bit_cnt_r  <= '0;
      data_r     <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      prescale_r <= 5'd0;
      tx_out_r   <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      timer_r   <= next_timer_s;
      bit_cnt_r <= next_bit_cnt_s;
      tx_out_r  <= next_tx_s;
      busy_r    <= next_busy_s;
      if (accept_s) begin
        data_r     <= bus.P_DATA;
        par_en_r   <= bus.PAR_EN;
        par_typ_r  <= bus.PAR_TYP;
        prescale_r <= eff_prescale(bus.Prescale);
      end else begin
        data_r     <= data_r;
        par_en_r   <= par_en_r;
        par_typ_r  <= par_typ_r;
        prescale_r <= prescale_r;
      end
    end
  end

  assign bus.TX_OUT = tx_out_r;
  assign bus.Busy   = busy_r;

endmodule
